// File: rtl/dca_pkg.sv
// -----------------------------------------------------------------------------
// dca_pkg
// Shared definitions for the decode / control / ALU block of the multi-cycle
// RV32I-subset datapath.
//
// Contents:
//   - opcode constants for the supported instruction classes
//   - global FSM state encodings (driven by the external controller)
//   - instruction class codes reported on the instr_type output
//   - ALU operation codes carried on alucontrol
//   - the packed control-signal bundle registered during EX
//   - opcode_to_type(): opcode -> instruction class lookup
//
// Configuration macro: DCA_EXT_ALU_EN (see rtl/decode_control_alu.sv).
// -----------------------------------------------------------------------------
package dca_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IARITH = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   // The encoding is not sequential; the external FSM owns these values.
   typedef enum logic [3:0] {
      ST_IF    = 4'b0000,
      ST_ID    = 4'b0001,
      ST_EX    = 4'b0010,
      ST_MEM   = 4'b0011,
      ST_WB    = 4'b0100,
      ST_AUX1  = 4'b0101,
      ST_AUX3  = 4'b0110,
      ST_AUX4  = 4'b0111,
      ST_SUMPC = 4'b1000,
      ST_FIM   = 4'b1001,
      ST_AUX2  = 4'b1111
   } state_t;

   typedef enum logic [2:0] {
      TYPE_R       = 3'b000,
      TYPE_LOAD    = 3'b001,
      TYPE_IARITH  = 3'b010,
      TYPE_S       = 3'b011,
      TYPE_B       = 3'b100,
      TYPE_UNKNOWN = 3'b111
   } instr_type_t;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_XOR = 4'b0011,
      ALU_SLL = 4'b0100,
      ALU_SRL = 4'b0101,
      ALU_SUB = 4'b0110
   } alu_op_t;

   typedef struct packed {
      logic    regiwrite;
      logic    memwrite;
      logic    memread;
      logic    branch;
      logic    memtoreg;
      logic    alusrc;
      alu_op_t alucontrol;
   } ctrl_t;

   // Idle control word: nothing written, nothing accessed, ALU adds.
   localparam ctrl_t CTRL_NOP = '{
      regiwrite:  1'b0,
      memwrite:   1'b0,
      memread:    1'b0,
      branch:     1'b0,
      memtoreg:   1'b0,
      alusrc:     1'b0,
      alucontrol: ALU_ADD
   };

   // Any opcode outside the supported subset maps to TYPE_UNKNOWN, so an
   // all-zero instruction word decodes as unknown rather than as a load.
   function automatic instr_type_t opcode_to_type(input logic [6:0] opcode);
      instr_type_t t;
      case (opcode)
         OP_R:      t = TYPE_R;
         OP_LOAD:   t = TYPE_LOAD;
         OP_IARITH: t = TYPE_IARITH;
         OP_STORE:  t = TYPE_S;
         OP_BRANCH: t = TYPE_B;
         default:   t = TYPE_UNKNOWN;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/dca_alu_core.sv
// -----------------------------------------------------------------------------
// dca_alu_core
// Purely combinational execute path: operand-B select, ALU operation and zero
// flag. The parent registers the outputs during the AUX1 state.
//
// Parameters:
//   XLEN          datapath width
// Ports:
//   operand_a     in  XLEN  rs1 value
//   operand_b_reg in  XLEN  rs2 value
//   immediate     in  12    raw 12-bit immediate (sign-extended here)
//   alusrc        in  1     1 selects the immediate as operand B
//   alucontrol    in  4     ALU operation code (dca_pkg::alu_op_t)
//   result        out XLEN  ALU result
//   zero          out 1     result == 0
//
// Configuration macro: DCA_EXT_ALU_EN adds AND, OR and SLL operations.
// -----------------------------------------------------------------------------
module dca_alu_core
   import dca_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b_reg,
   input  logic [11:0]     immediate,
   input  logic            alusrc,
   input  logic [3:0]      alucontrol,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] operand_b;

   // Immediates are signed 12-bit quantities: replicate bit 11 to full width.
   assign imm_ext   = {{(XLEN-12){immediate[11]}}, immediate};
   assign operand_b = alusrc ? imm_ext : operand_b_reg;

   // Shift amount uses only the low five bits of operand B, as RV32I does;
   // add/sub wrap modulo 2^XLEN. Unknown codes fall back to ADD.
   always_comb begin
      result = operand_a + operand_b;
      case (alu_op_t'(alucontrol))
         ALU_ADD: result = operand_a + operand_b;
         ALU_SUB: result = operand_a - operand_b;
         ALU_XOR: result = operand_a ^ operand_b;
         ALU_SRL: result = operand_a >> operand_b[4:0];
`ifdef DCA_EXT_ALU_EN
         ALU_AND: result = operand_a & operand_b;
         ALU_OR:  result = operand_a | operand_b;
         ALU_SLL: result = operand_a << operand_b[4:0];
`endif
         default: result = operand_a + operand_b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/decode_control_alu.sv
// -----------------------------------------------------------------------------
// decode_control_alu
// Decode, control generation and execute block of the multi-cycle RV32I-subset
// datapath (lw, sw, sub, xor, addi, srl, beq). Each part is captured in its own
// global FSM state: decode fields in ID, control signals in EX, ALU result in
// AUX1. All outputs hold their value in every other state.
//
// Parameters:
//   XLEN                      datapath width
// Ports:
//   clk                       in  1     rising-edge clock
//   rst                       in  1     asynchronous, active-low reset
//   state                     in  4     global FSM state (dca_pkg::state_t)
//   instruction               in  32    fetched instruction
//   read_data1, read_data2    in  XLEN  register-file operands (rs1, rs2)
//   opcode, rd, rs1, rs2,
//   funct3, funct7            out       decoded instruction fields
//   immediate                 out 12    raw immediate (B-type holds imm[12:1])
//   negative                  out 1     immediate sign bit
//   instr_type                out 3     instruction class (dca_pkg::instr_type_t)
//                                       ("type" is a SystemVerilog keyword)
//   regiwrite, memwrite, memread,
//   branch, memtoreg, alusrc  out 1     control signals
//   alucontrol                out 4     ALU operation code
//   aluresult2                out XLEN  ALU result
//   aluresult1                out 1     zero flag of the ALU result
//   pcsrc                     out 1     take branch
//
// Configuration macro: DCA_EXT_ALU_EN adds R-type add, and, or and sll.
// -----------------------------------------------------------------------------
module decode_control_alu
   import dca_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      state,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] read_data1,
   input  logic [XLEN-1:0] read_data2,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [11:0]     immediate,
   output logic            negative,
   output logic [2:0]      instr_type,
   output logic            regiwrite,
   output logic            memwrite,
   output logic            memread,
   output logic            branch,
   output logic            memtoreg,
   output logic            alusrc,
   output logic [3:0]      alucontrol,
   output logic [XLEN-1:0] aluresult2,
   output logic            aluresult1,
   output logic            pcsrc
);

   instr_type_t     dec_type;
   logic [11:0]     dec_imm;
   logic            dec_neg;
   ctrl_t           ctrl_next;
   ctrl_t           ctrl_q;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   // Instruction-class and immediate extraction straight from the fetched
   // word. The B-type immediate keeps imm[12:1]; the PC adder supplies the
   // implicit zero LSB by shifting left.
   always_comb begin
      dec_type = opcode_to_type(instruction[6:0]);
      dec_imm  = '0;
      dec_neg  = 1'b0;
      case (dec_type)
         TYPE_LOAD, TYPE_IARITH: begin
            dec_imm = instruction[31:20];
            dec_neg = instruction[31];
         end
         TYPE_S: begin
            dec_imm = {instruction[31:25], instruction[11:7]};
            dec_neg = instruction[31];
         end
         TYPE_B: begin
            dec_imm = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
            dec_neg = instruction[31];
         end
         default: begin
            dec_imm = '0;
            dec_neg = 1'b0;
         end
      endcase
   end

   // Decode register: refreshed only while the FSM sits in ID, so the fetched
   // instruction bus is free to change afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opcode     <= '0;
         rd         <= '0;
         rs1        <= '0;
         rs2        <= '0;
         funct3     <= '0;
         funct7     <= '0;
         immediate  <= '0;
         negative   <= 1'b0;
         instr_type <= TYPE_UNKNOWN;
      end else if (state == ST_ID) begin
         opcode     <= instruction[6:0];
         rd         <= instruction[11:7];
         funct3     <= instruction[14:12];
         rs1        <= instruction[19:15];
         rs2        <= instruction[24:20];
         funct7     <= instruction[31:25];
         immediate  <= dec_imm;
         negative   <= dec_neg;
         instr_type <= dec_type;
      end
   end

   // Control generation from the registered decode fields. Anything not in
   // the supported table stays at the no-op word (nothing written, ADD), so
   // an unrecognised instruction can never corrupt architectural state.
   always_comb begin
      ctrl_next = CTRL_NOP;
      case (instr_type_t'(instr_type))
         TYPE_LOAD: begin
            if (funct3 == 3'b010) begin
               ctrl_next.regiwrite = 1'b1;
               ctrl_next.memread   = 1'b1;
               ctrl_next.memtoreg  = 1'b1;
               ctrl_next.alusrc    = 1'b1;
            end
         end
         TYPE_S: begin
            if (funct3 == 3'b010) begin
               ctrl_next.memwrite = 1'b1;
               ctrl_next.alusrc   = 1'b1;
            end
         end
         TYPE_IARITH: begin
            if (funct3 == 3'b000) begin
               ctrl_next.regiwrite = 1'b1;
               ctrl_next.alusrc    = 1'b1;
            end
         end
         TYPE_B: begin
            if (funct3 == 3'b000) begin
               ctrl_next.branch     = 1'b1;
               ctrl_next.alucontrol = ALU_SUB;
            end
         end
         TYPE_R: begin
            case (funct3)
               3'b000: begin
                  if (funct7 == FUNCT7_ALT) begin
                     ctrl_next.regiwrite  = 1'b1;
                     ctrl_next.alucontrol = ALU_SUB;
                  end
`ifdef DCA_EXT_ALU_EN
                  else if (funct7 == FUNCT7_ZERO) begin
                     ctrl_next.regiwrite  = 1'b1;
                     ctrl_next.alucontrol = ALU_ADD;
                  end
`endif
               end
               3'b100: begin
                  if (funct7 == FUNCT7_ZERO) begin
                     ctrl_next.regiwrite  = 1'b1;
                     ctrl_next.alucontrol = ALU_XOR;
                  end
               end
               3'b101: begin
                  if (funct7 == FUNCT7_ZERO) begin
                     ctrl_next.regiwrite  = 1'b1;
                     ctrl_next.alucontrol = ALU_SRL;
                  end
               end
`ifdef DCA_EXT_ALU_EN
               3'b111: begin
                  if (funct7 == FUNCT7_ZERO) begin
                     ctrl_next.regiwrite  = 1'b1;
                     ctrl_next.alucontrol = ALU_AND;
                  end
               end
               3'b110: begin
                  if (funct7 == FUNCT7_ZERO) begin
                     ctrl_next.regiwrite  = 1'b1;
                     ctrl_next.alucontrol = ALU_OR;
                  end
               end
               3'b001: begin
                  if (funct7 == FUNCT7_ZERO) begin
                     ctrl_next.regiwrite  = 1'b1;
                     ctrl_next.alucontrol = ALU_SLL;
                  end
               end
`endif
               default: ctrl_next = CTRL_NOP;
            endcase
         end
         default: ctrl_next = CTRL_NOP;
      endcase
   end

   // Control register: captured in EX from the decode register, which has
   // been stable since the end of ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q <= CTRL_NOP;
      end else if (state == ST_EX) begin
         ctrl_q <= ctrl_next;
      end
   end

   assign regiwrite  = ctrl_q.regiwrite;
   assign memwrite   = ctrl_q.memwrite;
   assign memread    = ctrl_q.memread;
   assign branch     = ctrl_q.branch;
   assign memtoreg   = ctrl_q.memtoreg;
   assign alusrc     = ctrl_q.alusrc;
   assign alucontrol = ctrl_q.alucontrol;

   dca_alu_core #(
      .XLEN (XLEN)
   ) u_alu_core (
      .operand_a     (read_data1),
      .operand_b_reg (read_data2),
      .immediate     (immediate),
      .alusrc        (alusrc),
      .alucontrol    (alucontrol),
      .result        (alu_result),
      .zero          (alu_zero)
   );

   // Execute register: captured in AUX1 and then held through the memory,
   // write-back and PC-update states that consume it. The branch decision is
   // taken here so PC update sees a stable pcsrc.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aluresult2 <= '0;
         aluresult1 <= 1'b0;
         pcsrc      <= 1'b0;
      end else if (state == ST_AUX1) begin
         aluresult2 <= alu_result;
         aluresult1 <= alu_zero;
         pcsrc      <= ctrl_q.branch & alu_zero;
      end
   end

endmodule

// File: tb/tb_decode_control_alu.sv
// -----------------------------------------------------------------------------
// tb_decode_control_alu
// Self-checking bench for decode_control_alu. The stimulus process walks each
// instruction through the FSM states and queues hand-computed expected values;
// an independent monitor pops and compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_decode_control_alu;
   import dca_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      state;
   logic [31:0]     instruction;
   logic [XLEN-1:0] read_data1;
   logic [XLEN-1:0] read_data2;
   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [11:0]     immediate;
   logic            negative;
   logic [2:0]      instr_type;
   logic            regiwrite;
   logic            memwrite;
   logic            memread;
   logic            branch;
   logic            memtoreg;
   logic            alusrc;
   logic [3:0]      alucontrol;
   logic [XLEN-1:0] aluresult2;
   logic            aluresult1;
   logic            pcsrc;

   typedef enum int {
      F_OPCODE, F_RD, F_RS1, F_RS2, F_FUNCT3, F_FUNCT7, F_IMM, F_NEG, F_TYPE,
      F_REGW, F_MEMW, F_MEMR, F_BRANCH, F_MEMTOREG, F_ALUSRC, F_ALUCTL,
      F_RESULT, F_ZERO, F_PCSRC
   } field_t;

   typedef struct {
      string       tag;
      field_t      field;
      logic [31:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   check_count = 0;
   int   error_count = 0;
   int   cycle_count = 0;
   bit   done = 1'b0;

   always #5 clk = ~clk;

   decode_control_alu #(
      .XLEN (XLEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .state       (state),
      .instruction (instruction),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .opcode      (opcode),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .funct3      (funct3),
      .funct7      (funct7),
      .immediate   (immediate),
      .negative    (negative),
      .instr_type  (instr_type),
      .regiwrite   (regiwrite),
      .memwrite    (memwrite),
      .memread     (memread),
      .branch      (branch),
      .memtoreg    (memtoreg),
      .alusrc      (alusrc),
      .alucontrol  (alucontrol),
      .aluresult2  (aluresult2),
      .aluresult1  (aluresult1),
      .pcsrc       (pcsrc)
   );

   function automatic logic [31:0] get_field(input field_t f);
      logic [31:0] v;
      case (f)
         F_OPCODE:   v = {25'b0, opcode};
         F_RD:       v = {27'b0, rd};
         F_RS1:      v = {27'b0, rs1};
         F_RS2:      v = {27'b0, rs2};
         F_FUNCT3:   v = {29'b0, funct3};
         F_FUNCT7:   v = {25'b0, funct7};
         F_IMM:      v = {20'b0, immediate};
         F_NEG:      v = {31'b0, negative};
         F_TYPE:     v = {29'b0, instr_type};
         F_REGW:     v = {31'b0, regiwrite};
         F_MEMW:     v = {31'b0, memwrite};
         F_MEMR:     v = {31'b0, memread};
         F_BRANCH:   v = {31'b0, branch};
         F_MEMTOREG: v = {31'b0, memtoreg};
         F_ALUSRC:   v = {31'b0, alusrc};
         F_ALUCTL:   v = {28'b0, alucontrol};
         F_RESULT:   v = aluresult2;
         F_ZERO:     v = {31'b0, aluresult1};
         F_PCSRC:    v = {31'b0, pcsrc};
         default:    v = 32'hDEAD_BEEF;
      endcase
      return v;
   endfunction

   // Compare one queued expectation against the live DUT outputs.
   task automatic checkOutput(input exp_t e);
      logic [31:0] actual;
      actual = get_field(e.field);
      check_count++;
      if (actual !== e.value) begin
         error_count++;
         $display("[TB] FAIL %s %s: got 0x%0h expected 0x%0h",
                  e.tag, e.field.name(), actual, e.value);
      end
   endtask

   // Monitor: outputs are registered and held, so everything queued after a
   // posedge is compared on the following negedge.
   always @(negedge clk) begin
      cycle_count++;
      while (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front());
      end
      if (done) begin
         $display("CHECKS %0d ERRORS %0d", check_count, error_count);
         $finish;
      end
      if (cycle_count > 5000) begin
         error_count++;
         $display("[TB] FAIL watchdog: got %0d cycles expected at most 5000", cycle_count);
         $display("CHECKS %0d ERRORS %0d", check_count, error_count);
         $finish;
      end
   end

   task automatic push_exp(input string tag, input field_t f, input logic [31:0] v);
      exp_t e;
      e.tag   = tag;
      e.field = f;
      e.value = v;
      exp_q.push_back(e);
   endtask

   // Present a state for one clock edge, then return just after that edge.
   task automatic applyStimulus(input state_t st);
      state = st;
      @(posedge clk);
      #1;
   endtask

   task automatic exp_decode(input string tag, input logic [6:0] op, input logic [4:0] e_rd,
                             input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                             input logic [2:0] f3, input logic [6:0] f7,
                             input logic [11:0] imm, input logic neg, input logic [2:0] typ);
      push_exp(tag, F_OPCODE, {25'b0, op});
      push_exp(tag, F_RD,     {27'b0, e_rd});
      push_exp(tag, F_RS1,    {27'b0, e_rs1});
      push_exp(tag, F_RS2,    {27'b0, e_rs2});
      push_exp(tag, F_FUNCT3, {29'b0, f3});
      push_exp(tag, F_FUNCT7, {25'b0, f7});
      push_exp(tag, F_IMM,    {20'b0, imm});
      push_exp(tag, F_NEG,    {31'b0, neg});
      push_exp(tag, F_TYPE,   {29'b0, typ});
   endtask

   task automatic exp_ctrl(input string tag, input logic rw, input logic mw, input logic mr,
                           input logic br, input logic m2r, input logic asrc,
                           input logic [3:0] actl);
      push_exp(tag, F_REGW,     {31'b0, rw});
      push_exp(tag, F_MEMW,     {31'b0, mw});
      push_exp(tag, F_MEMR,     {31'b0, mr});
      push_exp(tag, F_BRANCH,   {31'b0, br});
      push_exp(tag, F_MEMTOREG, {31'b0, m2r});
      push_exp(tag, F_ALUSRC,   {31'b0, asrc});
      push_exp(tag, F_ALUCTL,   {28'b0, actl});
   endtask

   task automatic exp_alu(input string tag, input logic [31:0] res, input logic z, input logic pc);
      push_exp(tag, F_RESULT, res);
      push_exp(tag, F_ZERO,   {31'b0, z});
      push_exp(tag, F_PCSRC,  {31'b0, pc});
   endtask

   task automatic exp_reset(input string tag);
      exp_decode(tag, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1'b0, 3'b111);
      exp_ctrl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
      exp_alu(tag, 32'd0, 1'b0, 1'b0);
   endtask

   // Fetch + decode: instruction is scrambled right after ID so later
   // checks prove the decode register does not follow the bus.
   task automatic run_decode(input logic [31:0] instr);
      instruction = instr;
      applyStimulus(ST_IF);
      applyStimulus(ST_ID);
      instruction = 32'hFFFF_FFFF;
   endtask

   task automatic run_alu(input logic [31:0] a, input logic [31:0] b);
      read_data1 = a;
      read_data2 = b;
      applyStimulus(ST_AUX1);
   endtask

   // Walk the post-execute states with junk operands; the result must hold.
   task automatic run_tail(input string tag, input logic [31:0] res, input logic z,
                           input logic pc, input logic [11:0] imm);
      read_data1 = 32'h1234_5678;
      read_data2 = 32'h0F0F_0F0F;
      applyStimulus(ST_AUX2);
      applyStimulus(ST_MEM);
      applyStimulus(ST_WB);
      applyStimulus(ST_AUX3);
      applyStimulus(ST_AUX4);
      applyStimulus(ST_SUMPC);
      applyStimulus(ST_FIM);
      exp_alu({tag, "_hold"}, res, z, pc);
      push_exp({tag, "_hold"}, F_IMM, {20'b0, imm});
   endtask

   initial begin
      rst         = 1'b0;
      state       = ST_IF;
      instruction = 32'd0;
      read_data1  = '0;
      read_data2  = '0;
      @(posedge clk);
      #1;
      exp_reset("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // addi x1,x0,5
      run_decode(32'h0050_0093);
      exp_decode("addi", 7'h13, 5'd1, 5'd0, 5'd5, 3'd0, 7'd0, 12'd5, 1'b0, 3'b010);
      applyStimulus(ST_EX);
      exp_ctrl("addi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
      run_alu(32'd0, 32'd99);
      exp_alu("addi", 32'd5, 1'b0, 1'b0);
      run_tail("addi", 32'd5, 1'b0, 1'b0, 12'd5);

      // lw x5,-4(x1)
      run_decode(32'hFFC0_A283);
      exp_decode("lw", 7'h03, 5'd5, 5'd1, 5'd28, 3'd2, 7'h7F, 12'hFFC, 1'b1, 3'b001);
      applyStimulus(ST_EX);
      exp_ctrl("lw", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010);
      run_alu(32'd100, 32'd7);
      exp_alu("lw", 32'd96, 1'b0, 1'b0);

      // sw x2,4(x1)
      run_decode(32'h0020_A223);
      exp_decode("sw", 7'h23, 5'd4, 5'd1, 5'd2, 3'd2, 7'd0, 12'd4, 1'b0, 3'b011);
      applyStimulus(ST_EX);
      exp_ctrl("sw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
      run_alu(32'd100, 32'd55);
      exp_alu("sw", 32'd104, 1'b0, 1'b0);

      // sub x3,x1,x2 with equal operands
      run_decode(32'h4020_81B3);
      exp_decode("sub", 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 12'd0, 1'b0, 3'b000);
      applyStimulus(ST_EX);
      exp_ctrl("sub", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
      run_alu(32'd7, 32'd7);
      exp_alu("sub", 32'd0, 1'b1, 1'b0);

      // xor x3,x1,x2
      run_decode(32'h0020_C1B3);
      applyStimulus(ST_EX);
      exp_ctrl("xor", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011);
      run_alu(32'hF0F0_00FF, 32'h0FF0_0F0F);
      exp_alu("xor", 32'hFF00_0FF0, 1'b0, 1'b0);

      // srl x4,x1,x2: shift 0x21 uses only the low five bits
      run_decode(32'h0020_D233);
      exp_decode("srl", 7'h33, 5'd4, 5'd1, 5'd2, 3'd5, 7'd0, 12'd0, 1'b0, 3'b000);
      applyStimulus(ST_EX);
      exp_ctrl("srl", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101);
      run_alu(32'h8000_0000, 32'h0000_0021);
      exp_alu("srl", 32'h4000_0000, 1'b0, 1'b0);

      // add x3,x1,x2: only recognised with the extended ALU
      run_decode(32'h0020_81B3);
      applyStimulus(ST_EX);
`ifdef DCA_EXT_ALU_EN
      exp_ctrl("add", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
`else
      exp_ctrl("add", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
`endif
      run_alu(32'hFFFF_FFFF, 32'd2);
      exp_alu("add", 32'd1, 1'b0, 1'b0);

      // beq x1,x2,+8 taken (3 == 3)
      run_decode(32'h0020_8463);
      exp_decode("beq", 7'h63, 5'd8, 5'd1, 5'd2, 3'd0, 7'd0, 12'd4, 1'b0, 3'b100);
      applyStimulus(ST_EX);
      exp_ctrl("beq", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110);
      run_alu(32'd3, 32'd3);
      exp_alu("beq_taken", 32'd0, 1'b1, 1'b1);
      run_tail("beq_taken", 32'd0, 1'b1, 1'b1, 12'd4);

      // beq not taken (3 != 4)
      run_decode(32'h0020_8463);
      applyStimulus(ST_EX);
      run_alu(32'd3, 32'd4);
      exp_alu("beq_not", 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Zero instruction, then reset in the middle of EX
      run_decode(32'h0000_0000);
      exp_decode("zero_instr", 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 1'b0, 3'b111);
      applyStimulus(ST_EX);
      exp_ctrl("zero_instr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
      push_exp("zero_instr_stale", F_RESULT, 32'hFFFF_FFFF);
      @(negedge clk);
      state = ST_AUX1;
      #1;
      rst = 1'b0;
      #1;
      exp_reset("mid_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Clean restart: sw after the reset
      run_decode(32'h0020_A223);
      applyStimulus(ST_EX);
      exp_ctrl("sw_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
      run_alu(32'd16, 32'd0);
      exp_alu("sw_after_rst", 32'd20, 1'b0, 1'b0);
      applyStimulus(ST_IF);

      done = 1'b1;
   end

endmodule

// File: doc/decode_control_alu.md
Name: decode_control_alu

Overview:
- Combined decode, control-generation and execute block of the multi-cycle RV32I-subset datapath.
- Supported instructions: lw, sw, sub, xor, addi, srl, beq.
- Takes the fetched instruction and the global FSM state, and registers the decoded fields, the control signals and the ALU result in successive FSM states.
- Sits between instruction fetch, the register file, data memory and PC update.

Parameters:
- XLEN, 32, datapath width of register operands and ALU result.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- state  in  4  global FSM state: IF=0000, ID=0001, EX=0010, AUX1=0101, AUX2=1111, MEM=0011, WB=0100, AUX3=0110, AUX4=0111, SUMPC=1000, FIM=1001
- instruction  in  32  fetched instruction
- read_data1, read_data2  in  XLEN  register-file operands for rs1 and rs2
- opcode  out  7; rd, rs1, rs2  out  5 each; funct3  out  3; funct7  out  7  decoded fields
- immediate  out  12  raw immediate
- negative  out  1  immediate sign bit
- type  out  3  instruction class
- regiwrite, memwrite, memread, branch, memtoreg, alusrc  out  1 each  control signals
- alucontrol  out  4  ALU operation code
- aluresult2  out  XLEN  ALU result
- aluresult1  out  1  zero flag (aluresult2 == 0)
- pcsrc  out  1  take branch

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, except type=111 and alucontrol=0010.
- Decode stage: registered on the clk edge while state==ID.
  - Field extraction: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
  - type encoding: 0110011→000 (R); 0000011→001 (load); 0010011→010 (I-arith); 0100011→011 (S); 1100011→100 (B); any other opcode→111. A zero instruction therefore yields type 111.
  - immediate by type:
    - I/load: [31:20]
    - S: {[31:25],[11:7]}
    - B: {[31],[7],[30:25],[11:8]}, i.e. imm[12:1]; the PC adder shifts it left by 1
    - R or unknown: 0
  - negative = instruction[31] for I/load/S/B types, else 0.
- Control stage: registered on the clk edge while state==EX, computed from the decoded fields. Each line lists the signals set to 1, then alucontrol; all other control signals are 0.
  - lw (load, f3=010): regiwrite, memread, memtoreg, alusrc; ADD
  - sw (S, f3=010): memwrite, alusrc; ADD
  - addi (I-arith, f3=000): regiwrite, alusrc; ADD
  - sub (R, f3=000, f7=0100000): regiwrite; SUB
  - xor (R, f3=100, f7=0): regiwrite; XOR
  - srl (R, f3=101, f7=0): regiwrite; SRL
  - beq (B, f3=000): branch; SUB
  - Any other combination, including unknown type: all control signals 0, alucontrol=ADD (harmless no-op).
- alucontrol codes: ADD=0010, SUB=0110, XOR=0011, SRL=0101.
- ALU stage: registered on the clk edge while state==AUX1; results are stable through AUX2, MEM, WB, AUX3, AUX4, SUMPC.
  - Operand B = alusrc ? sign-extended immediate (bit 11 replicated to XLEN) : read_data2.
  - ADD/SUB: modulo 2^XLEN, wrap-around silently ignored.
  - XOR: bitwise.
  - SRL: logical shift of A by B[4:0].
  - aluresult1 = (result == 0).
  - pcsrc = branch & aluresult1.
- Outside these three capture states, all outputs hold their values.
- A new ID capture overwrites the decode outputs. Control and ALU outputs keep stale values until their own stage, which is harmless because the FSM never reads them early.
- Reset mid-operation clears everything immediately; the next instruction starts cleanly from IF.

Optional Feature:
- Macro DCA_EXT_ALU_EN.
- Defined: additionally supports R-type add (f3=000, f7=0 → ADD), and (f3=111 → AND=0000), or (f3=110 → OR=0001) and sll (f3=001 → SLL=0100). All of these have regiwrite=1.
- Undefined: those encodings decode as unsupported, with all control signals 0.

Decomposition:
- Package dca_pkg: opcode constants, state encodings, type codes, alucontrol codes.
- Sub-module dca_alu_core: purely combinational operand-B mux, ALU operation and zero flag; its outputs are registered in the top module.

Test Plan:
- addi x1,x0,5 (0x00500093), read_data1=0:
  - after ID: rd=1, immediate=5, type=010
  - after EX: regiwrite=1, alusrc=1, alucontrol=0010
  - after AUX1: aluresult2=5
- lw x5,-4(x1) (0xFFC0A283), read_data1=100:
  - decode: negative=1, immediate=0xFFC
  - control: memread=1, memtoreg=1
  - aluresult2=96
- sub x3,x1,x2 (0x402081B3) with read_data1=read_data2=7:
  - alucontrol=0110, aluresult2=0, aluresult1=1, pcsrc=0
- srl x4,x1,x2 (0x0020D233), read_data1=0x80000000, read_data2=0x21:
  - aluresult2=0x40000000 (shift amount taken from [4:0] only)
- beq x1,x2,+8 (0x00208463):
  - immediate=4, branch=1
  - operands 3/3 → pcsrc=1; operands 3/4 → pcsrc=0
- Instruction 0:
  - type=111, all control signals 0
  - rst pulled low mid-EX → all outputs 0 immediately, alucontrol=0010, type=111
